ring_counter_monitor: RTL and testbench

//  Downstream checker for the one-hot ring_counter: samples its q bus every clk,

---
 rtl/ring_counter_monitor.sv | 131 +++++++++++++
 tb/tb_ring_counter_monitor.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ring_counter_monitor.sv
// Downstream checker for a one-hot rotate-left ring counter: tracks lock, rotations and faults.
// Optional build macro RING_MON_STICKY_ERR_EN makes FAULT absorbing until clr.
module ring_counter_monitor #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned LOCK_CNT = 2,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           q_in,
   input  logic                       clr,
   output logic                       locked,
   output logic                       err,
   output logic                       wrap,
   output logic [$clog2(WIDTH)-1:0]   phase_idx,
   output logic [CNT_W-1:0]           rot_cnt,
   output logic [CNT_W-1:0]           err_cnt
);

   localparam int unsigned IDX_W = $clog2(WIDTH);
   localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);

   localparam logic [1:0] SEARCH = 2'd0;
   localparam logic [1:0] LOCKED = 2'd1;
   localparam logic [1:0] FAULT  = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [RUN_W-1:0] run, run_nxt;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_exp;
   logic             legal;
   logic             err_nxt, wrap_nxt;
   logic [CNT_W-1:0] rot_nxt, errc_nxt;
   logic [IDX_W-1:0] phase_nxt;

   // A legal step is a one-hot value equal to the previous sample rotated left.
   assign q_exp = {q_d[WIDTH-2:0], q_d[WIDTH-1]};
   assign legal = $onehot(q_in) && (q_in == q_exp);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SEARCH;
         run   <= '0;
      end else begin
         state <= state_nxt;
         run   <= run_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      run_nxt   = run;
      err_nxt   = 1'b0;
      wrap_nxt  = 1'b0;
      rot_nxt   = rot_cnt;
      errc_nxt  = err_cnt;
      case (state)
         SEARCH: begin
            if (legal) begin
               if (run == RUN_W'(LOCK_CNT - 1)) begin
                  state_nxt = LOCKED;
                  run_nxt   = '0;
               end else begin
                  run_nxt = run + RUN_W'(1);
               end
            end else begin
               run_nxt = '0;
            end
         end
         LOCKED: begin
            if (legal) begin
               if (q_in == WIDTH'(1)) begin
                  wrap_nxt = 1'b1;
                  rot_nxt  = rot_cnt + CNT_W'(1);
               end
            end else begin
               state_nxt = FAULT;
               err_nxt   = 1'b1;
               if (err_cnt != '1) errc_nxt = err_cnt + CNT_W'(1);
            end
         end
         FAULT: begin
            run_nxt = '0;
`ifdef RING_MON_STICKY_ERR_EN
            if (clr) state_nxt = SEARCH;
`else
            state_nxt = SEARCH;
`endif
         end
         default: begin
            state_nxt = SEARCH;
            run_nxt   = '0;
         end
      endcase
      // Clear wins over any same-cycle increment.
      if (clr) begin
         rot_nxt  = '0;
         errc_nxt = '0;
      end
   end

   always_comb begin
      phase_nxt = '0;
      if ($onehot(q_in)) begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            if (q_in[i]) phase_nxt = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_d       <= '0;
         locked    <= 1'b0;
         err       <= 1'b0;
         wrap      <= 1'b0;
         phase_idx <= '0;
         rot_cnt   <= '0;
         err_cnt   <= '0;
      end else begin
         q_d       <= q_in;
         locked    <= (state_nxt == LOCKED);
         err       <= err_nxt;
         wrap      <= wrap_nxt;
         phase_idx <= phase_nxt;
         rot_cnt   <= rot_nxt;
         err_cnt   <= errc_nxt;
      end
   end

endmodule

// File: tb/tb_ring_counter_monitor.sv
// Randomized bench for ring_counter_monitor against an index-based behavioural model.
module tb_ring_counter_monitor;
   localparam int W  = 4;
   localparam int LC = 2;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr = 1'b0;
   logic [W-1:0]  q_in = '0;
   logic          locked, err, wrap;
   logic [1:0]    phase_idx;
   logic [CW-1:0] rot_cnt, err_cnt;

   ring_counter_monitor #(.WIDTH(W), .LOCK_CNT(LC), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .q_in(q_in), .clr(clr),
      .locked(locked), .err(err), .wrap(wrap), .phase_idx(phase_idx),
      .rot_cnt(rot_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got=%0d expected=%0d", tag, $time, got, exp);
      end
   endtask

   // Model: positions as integers, -1 meaning "not one-hot".
   int m_prev, m_streak, m_rot, m_errc, m_phase;
   bit m_lk, m_fault, m_err, m_wrap;

   function automatic int idx_of(input logic [W-1:0] v);
      int n = 0;
      int p = -1;
      for (int i = 0; i < W; i++) if (v[i]) begin n++; p = i; end
      return (n == 1) ? p : -1;
   endfunction

   task automatic model_reset();
      m_prev = -1; m_streak = 0; m_rot = 0; m_errc = 0; m_phase = 0;
      m_lk = 0; m_fault = 0; m_err = 0; m_wrap = 0;
   endtask

   task automatic model_step(input logic [W-1:0] v, input bit c);
      int  cur = idx_of(v);
      bit  ok  = (cur >= 0) && (m_prev >= 0) && (cur == (m_prev + 1) % W);
      m_err  = 0;
      m_wrap = 0;
      if (m_fault) begin
         m_streak = 0;
`ifdef RING_MON_STICKY_ERR_EN
         if (c) m_fault = 0;
`else
         m_fault = 0;
`endif
      end else if (m_lk) begin
         if (ok) begin
            if (cur == 0) begin
               m_wrap = 1;
               m_rot  = (m_rot + 1) % (1 << CW);
            end
         end else begin
            m_lk = 0; m_fault = 1; m_err = 1;
            if (m_errc < (1 << CW) - 1) m_errc++;
         end
      end else begin
         if (ok) begin
            m_streak++;
            if (m_streak == LC) begin m_lk = 1; m_streak = 0; end
         end else begin
            m_streak = 0;
         end
      end
      if (c) begin m_rot = 0; m_errc = 0; end
      m_prev  = cur;
      m_phase = (cur < 0) ? 0 : cur;
   endtask

   task automatic check_all();
      chk("locked",    32'(locked),    32'(m_lk));
      chk("err",       32'(err),       32'(m_err));
      chk("wrap",      32'(wrap),      32'(m_wrap));
      chk("phase_idx", 32'(phase_idx), 32'(m_phase));
      chk("rot_cnt",   32'(rot_cnt),   32'(m_rot));
      chk("err_cnt",   32'(err_cnt),   32'(m_errc));
   endtask

   initial begin
      int pos = 0;
      int r;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst = 1'b0;
      for (int cyc = 0; cyc < 900; cyc++) begin
         @(negedge clk);
         if (cyc == 450) begin
            // Async reset mid-operation: outputs must drop before any clock edge.
            rst = 1'b1;
            #1;
            model_reset();
            chk("rst_locked",  32'(locked),    0);
            chk("rst_rot_cnt", 32'(rot_cnt),   0);
            chk("rst_err_cnt", 32'(err_cnt),   0);
            chk("rst_phase",   32'(phase_idx), 0);
            pos = 0;
            @(negedge clk);
            rst = 1'b0;
         end
         r = int'($urandom_range(0, 99));
         if (cyc < 40 || r >= 10) begin
            q_in = W'(1) << pos;
            pos  = (pos + 1) % W;
         end else if (r < 4) begin
            q_in = W'($urandom);
         end else if (r < 8) begin
            q_in = q_in;
         end else begin
            q_in = '0;
         end
         clr = (cyc >= 40) && ($urandom_range(0, 99) < 2);
         @(posedge clk);
         model_step(q_in, clr);
         #1;
         check_all();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
